// File: rtl/co_controller_if.sv
// co_controller_if: command/datapath bundle for co_controller; slave = controller side, master = command source + datapath side
interface co_controller_if #(parameter int WIDTH = 8);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] x0;
  logic [WIDTH-1:0] y0;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             load_x;
  logic             load_y;
  logic             subtract_x;
  logic             subtract_y;
  logic             add_x;
  logic             add_y;
  logic             busy;
  logic             done;
  logic             err;
  modport slave (
    input  start, op, x0, y0, x, y,
    output load_x, load_y, subtract_x, subtract_y, add_x, add_y, busy, done, err
  );
  modport master (
    output start, op, x0, y0, x, y,
    input  load_x, load_y, subtract_x, subtract_y, add_x, add_y, busy, done, err
  );
endinterface

// File: rtl/co_controller.sv
// co_controller: sequencing FSM driving x/y datapath strobes for GCD (repeated subtraction) and, with CO_MUL_EN, multiply (repeated addition)
// Ports: clk (rising edge), reset (async, active-low), bus (co_controller_if.slave: start/op/x0/y0 command,
//   x/y datapath feedback, load/subtract/add strobes, busy/done/err status).
// Macro CO_MUL_EN: compiles in the MUL state and its countdown; otherwise op is ignored and add_x is 0.
module co_controller #(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            reset,
  co_controller_if.slave bus
);
`ifdef CO_MUL_EN
  typedef enum logic [2:0] {IDLE, LOAD, GCD, MUL, DONE} state_t;
  logic             op_q;
  logic [WIDTH-1:0] cnt_q;
`else
  typedef enum logic [2:0] {IDLE, LOAD, GCD, DONE} state_t;
`endif
  state_t state_q;
  logic   busy_q, done_q, err_q, zero_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      zero_q  <= 1'b0;
`ifdef CO_MUL_EN
      op_q    <= 1'b0;
      cnt_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          state_q <= LOAD;
          busy_q  <= 1'b1;
          err_q   <= 1'b0;
          zero_q  <= (bus.x0 == '0) || (bus.y0 == '0);
`ifdef CO_MUL_EN
          op_q    <= bus.op;
          cnt_q   <= bus.y0;
`endif
        end
        LOAD: begin
          busy_q  <= !zero_q;
          done_q  <= zero_q;
          err_q   <= zero_q;
`ifdef CO_MUL_EN
          state_q <= zero_q ? DONE : (op_q ? MUL : GCD);
`else
          state_q <= zero_q ? DONE : GCD;
`endif
        end
        GCD: if (bus.x == bus.y) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
`ifdef CO_MUL_EN
        // cnt starts at B, so B-1 additions of A onto x=A leave x=A*B
        MUL: if (cnt_q == WIDTH'(1)) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          cnt_q   <= cnt_q - 1'b1;
        end
`endif
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.load_x     = state_q == LOAD;
  assign bus.load_y     = state_q == LOAD;
  assign bus.subtract_x = (state_q == GCD) && (bus.x > bus.y);
  assign bus.subtract_y = (state_q == GCD) && (bus.x < bus.y);
`ifdef CO_MUL_EN
  assign bus.add_x      = (state_q == MUL) && (cnt_q != WIDTH'(1));
`else
  assign bus.add_x      = 1'b0;
`endif
  assign bus.add_y      = 1'b0;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_co_controller.sv
// tb_co_controller: randomized + directed checks of co_controller against an arithmetic reference model
module tb_co_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  co_controller_if #(.WIDTH(8)) bus ();
  co_controller #(.WIDTH(8)) dut (.clk(clk), .reset(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // behavioural datapath: add_x accumulates the held operand A
  always @(posedge clk) begin
    if (bus.load_x) bus.x <= bus.x0;
    if (bus.load_y) bus.y <= bus.y0;
    if (bus.subtract_x) bus.x <= bus.x - bus.y;
    if (bus.subtract_y) bus.y <= bus.y - bus.x;
    if (bus.add_x) bus.x <= bus.x + bus.x0;
  end
  task automatic check(input string tag, input int obs, input int exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask
  // Euclid: subtractive step count is the sum of quotients minus one
  function automatic void model_gcd(input int a, input int b, output int g, output int k);
    int q = 0;
    int t;
    while (b != 0) begin
      q += a / b;
      t = a % b;
      a = b;
      b = t;
    end
    g = a;
    k = q - 1;
  endfunction
  task automatic run_op(input int a, input int b, input logic o, input bit pulse, input string tag);
    int g, k, exp_done, exp_x, exp_y, exp_subs, exp_adds, exp_err;
    int cyc, done_cyc, subs, adds, multi, load_bad, busy_bad, addy_bad;
    bit is_mul;
`ifdef CO_MUL_EN
    is_mul = o;
`else
    is_mul = 1'b0;
`endif
    exp_subs = 0; exp_adds = 0; exp_err = 0;
    if (a == 0 || b == 0) begin
      exp_done = 2; exp_x = a; exp_y = b; exp_err = 1;
    end else if (is_mul) begin
      exp_done = b + 2; exp_x = (a * b) % 256; exp_y = b; exp_adds = b - 1;
    end else begin
      model_gcd(a, b, g, k);
      exp_done = k + 3; exp_x = g; exp_y = g; exp_subs = k;
    end
    @(negedge clk);
    bus.start = 1'b1; bus.x0 = 8'(a); bus.y0 = 8'(b); bus.op = o;
    cyc = 1; done_cyc = -1; subs = 0; adds = 0; multi = 0; load_bad = 0; busy_bad = 0; addy_bad = 0;
    @(posedge clk);
    forever begin
      #1;
      if (int'(bus.load_x) + int'(bus.load_y) + int'(bus.subtract_x) + int'(bus.subtract_y) + int'(bus.add_x) > 1 + int'(cyc == 1)) multi++;
      if (bus.load_x !== (cyc == 1) || bus.load_y !== (cyc == 1)) load_bad++;
      if (bus.busy !== (cyc < exp_done)) busy_bad++;
      if (bus.add_y !== 1'b0) addy_bad++;
      subs += int'(bus.subtract_x) + int'(bus.subtract_y);
      adds += int'(bus.add_x);
      if (bus.done === 1'b1) begin
        done_cyc = cyc;
        check({tag, " x"}, int'(bus.x), exp_x);
        check({tag, " y"}, int'(bus.y), exp_y);
        check({tag, " err"}, int'(bus.err), exp_err);
        break;
      end
      if (cyc >= 400) break;
      @(negedge clk);
      bus.start = pulse && cyc <= 4;
      @(posedge clk);
      cyc++;
    end
    check({tag, " done_cycle"}, done_cyc, exp_done);
    check({tag, " subs"}, subs, exp_subs);
    check({tag, " adds"}, adds, exp_adds);
    check({tag, " strobe_overlap"}, multi, 0);
    check({tag, " load_timing"}, load_bad, 0);
    check({tag, " busy_timing"}, busy_bad, 0);
    check({tag, " add_y"}, addy_bad, 0);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " done_pulse_len"}, int'(bus.done), 0);
    check({tag, " err_held"}, int'(bus.err), exp_err);
  endtask
  initial begin
    int done_seen;
    bus.start = 1'b0; bus.op = 1'b0; bus.x0 = '0; bus.y0 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    check("reset err", int'(bus.err), 0);
    check("reset strobes", int'({bus.load_x, bus.load_y, bus.subtract_x, bus.subtract_y, bus.add_x, bus.add_y}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(12, 18, 1'b0, 1'b0, "gcd12_18");
    run_op(255, 1, 1'b0, 1'b0, "gcd255_1");
    run_op(0, 5, 1'b0, 1'b0, "gcd0_5");
    run_op(4, 6, 1'b0, 1'b0, "gcd4_6");
    run_op(5, 0, 1'b1, 1'b0, "mul5_0");
    run_op(4, 6, 1'b0, 1'b0, "gcd4_6b");
    run_op(12, 18, 1'b0, 1'b1, "gcd_start_pulse");
    run_op(12, 18, 1'b1, 1'b0, "op1_12_18");
    run_op(7, 9, 1'b1, 1'b0, "mul7_9");
    run_op(20, 20, 1'b1, 1'b0, "mul20_20");
    for (int i = 0; i < 8; i++)
      run_op(int'($urandom_range(1, 60)), int'($urandom_range(1, 60)), 1'($urandom_range(0, 1)), 1'b0, "rand");
    // reset asserted in cycle 3 of GCD(12,18)
    @(negedge clk);
    bus.start = 1'b1; bus.x0 = 8'd12; bus.y0 = 8'd18; bus.op = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("pre_reset subtract_x", int'(bus.subtract_x), 1);
    rst_n = 1'b0;
    #1;
    check("mid_reset strobes", int'({bus.load_x, bus.load_y, bus.subtract_x, bus.subtract_y, bus.add_x}), 0);
    check("mid_reset busy", int'(bus.busy), 0);
    done_seen = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      done_seen += int'(bus.done === 1'b1) + int'(bus.busy === 1'b1);
    end
    check("post_reset no_done", done_seen, 0);
    run_op(12, 18, 1'b0, 1'b0, "after_reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
